// File: rtl/sum_accumulator_pkg.sv
// Shared types and width helpers for the sum accumulator and its handshake interface.
// Latency: n/a (types and constant functions only).
// Backpressure: n/a.
package sum_accumulator_pkg;

    // Controller states: gathering samples, or holding a finished total for the consumer.
    typedef enum logic {
        ACCUM = 1'b0,
        HOLD  = 1'b1
    } acc_state_t;

    // Accumulator width: the (n+1)-bit sum plus enough headroom for COUNT additions.
    function automatic int acc_width(input int n, input int count);
        return n + 1 + $clog2(count);
    endfunction

    // Sample counter width; a COUNT of 1 still needs a one-bit counter.
    function automatic int cnt_width(input int count);
        return (count > 1) ? $clog2(count) : 1;
    endfunction

endpackage

// File: rtl/sum_accumulator_if.sv
// Valid/ready bundle carrying adder sums in and batch totals out.
// Latency: n/a (wiring only).
// Backpressure: in_ready / out_ready carry it in each direction.
interface sum_accumulator_if
    import sum_accumulator_pkg::*;
#(
    parameter int N     = 3,
    parameter int COUNT = 4
);
    localparam int ACC_W = acc_width(N, COUNT);

    logic             in_valid;
    logic             in_ready;
    logic [N:0]       in_sum;
    logic             out_valid;
    logic             out_ready;
    logic [ACC_W-1:0] out_acc;

    // Environment side: produces sums, consumes totals.
    modport master (
        output in_valid, in_sum, out_ready,
        input  in_ready, out_valid, out_acc
    );

    // Accumulator side.
    modport slave (
        input  in_valid, in_sum, out_ready,
        output in_ready, out_valid, out_acc
    );
endinterface

// File: rtl/sum_accumulator.sv
// Sums COUNT consecutive adder outputs into one unsigned batch total.
// Latency: out_valid rises the cycle after the COUNT-th input handshake.
// Backpressure: in_ready is low while a total waits; the total holds until out_ready.
module sum_accumulator
    import sum_accumulator_pkg::*;
#(
    parameter int N     = 3,
    parameter int COUNT = 4
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               clear,
    output logic               busy,
    sum_accumulator_if.slave   bus
);
    localparam int ACC_W = acc_width(N, COUNT);
    localparam int CNT_W = cnt_width(COUNT);
    localparam logic [CNT_W-1:0] LAST = CNT_W'(COUNT - 1);

    acc_state_t       state;
    logic [ACC_W-1:0] acc;
    logic [CNT_W-1:0] cnt;
    logic [ACC_W-1:0] acc_next;
    logic [ACC_W-1:0] out_acc_q;
    logic             out_valid_q;
    logic             in_ready_q;
    logic             busy_q;
    logic             accept;

    // Running sum including the sample on the bus; width guarantees no wrap.
    always_comb begin
        acc_next = acc + ACC_W'(bus.in_sum);
        accept   = bus.in_valid & in_ready_q;
    end

    // Batch controller: all outputs are registered alongside the state.
    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= ACCUM;
            acc         <= '0;
            cnt         <= '0;
            out_acc_q   <= '0;
            out_valid_q <= 1'b0;
            in_ready_q  <= 1'b1;
            busy_q      <= 1'b0;
        end else begin
            case (state)
                ACCUM: begin
                    if (clear) begin
                        // Abort wins over a same-cycle sample.
                        acc    <= '0;
                        cnt    <= '0;
                        busy_q <= 1'b0;
                    end else if (accept) begin
                        if (cnt == LAST) begin
                            out_acc_q   <= acc_next;
                            acc         <= '0;
                            cnt         <= '0;
                            busy_q      <= 1'b0;
                            out_valid_q <= 1'b1;
                            in_ready_q  <= 1'b0;
                            state       <= HOLD;
                        end else begin
                            acc    <= acc_next;
                            cnt    <= cnt + CNT_W'(1);
                            busy_q <= 1'b1;
                        end
                    end
                end
                HOLD: begin
                    // clear is ignored here so a finished total is never dropped.
                    if (bus.out_ready) begin
                        out_valid_q <= 1'b0;
                        in_ready_q  <= 1'b1;
                        state       <= ACCUM;
                    end
                end
                default: begin
                    state <= ACCUM;
                end
            endcase
        end
    end

    assign bus.in_ready  = in_ready_q;
    assign bus.out_valid = out_valid_q;
    assign bus.out_acc   = out_acc_q;
    assign busy          = busy_q;

endmodule

// File: tb/tb_sum_accumulator.sv
// Directed self-checking bench for sum_accumulator in three configurations.
// Expected totals go into per-instance queues when the closing sample is driven.
// Queues are popped whenever an output handshake is observed.
module tb_sum_accumulator;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic clear10 = 1'b0;
    logic clear3  = 1'b0;
    logic clear1  = 1'b0;
    logic busy10, busy3, busy1;

    int n_assert = 0;
    int n_fail   = 0;
    int q10[$];
    int q3[$];
    int q1[$];

    always #5 clk = ~clk;

    sum_accumulator_if #(.N(10), .COUNT(4)) if10 ();
    sum_accumulator_if #(.N(3),  .COUNT(4)) if3 ();
    sum_accumulator_if #(.N(3),  .COUNT(1)) if1 ();

    sum_accumulator #(.N(10), .COUNT(4)) u10 (
        .clk(clk), .rst(rst), .clear(clear10), .busy(busy10), .bus(if10));
    sum_accumulator #(.N(3), .COUNT(4)) u3 (
        .clk(clk), .rst(rst), .clear(clear3), .busy(busy3), .bus(if3));
    sum_accumulator #(.N(3), .COUNT(1)) u1 (
        .clk(clk), .rst(rst), .clear(clear1), .busy(busy1), .bus(if1));

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic pop_chk(input string tag, input logic [31:0] obs, inout int q[$]);
        if (q.size() == 0) begin
            chk({tag, "_unexpected_output"}, 32'd1, 32'd0);
        end else begin
            chk(tag, obs, 32'(q.pop_front()));
        end
    endtask

    // One clock: check output handshakes at the falling edge, then return just after the rising edge.
    task automatic tick();
        @(negedge clk);
        if (if10.out_valid && if10.out_ready) pop_chk("sb10", 32'(if10.out_acc), q10);
        if (if3.out_valid && if3.out_ready)   pop_chk("sb3",  32'(if3.out_acc),  q3);
        if (if1.out_valid && if1.out_ready)   pop_chk("sb1",  32'(if1.out_acc),  q1);
        @(posedge clk);
        #1;
    endtask

    task automatic feed10(input int s);
        if10.in_valid = 1'b1;
        if10.in_sum   = 11'(s);
        tick();
    endtask

    initial begin
        int batch[4];
        batch = '{100, 99, 99, 147};

        if10.in_valid = 1'b0; if10.in_sum = '0; if10.out_ready = 1'b1;
        if3.in_valid  = 1'b0; if3.in_sum  = '0; if3.out_ready  = 1'b1;
        if1.in_valid  = 1'b0; if1.in_sum  = '0; if1.out_ready  = 1'b1;

        // Reset state
        tick();
        tick();
        rst = 1'b0;
        chk("rst_out_valid", 32'(if10.out_valid), 32'd0);
        chk("rst_out_acc",   32'(if10.out_acc),   32'd0);
        chk("rst_in_ready",  32'(if10.in_ready),  32'd1);
        chk("rst_busy",      32'(busy10),         32'd0);

        // Basic batch with out_ready held high
        for (int i = 0; i < 4; i++) begin
            if (i == 3) q10.push_back(445);
            feed10(batch[i]);
            if (i == 1) chk("busy_mid", 32'(busy10), 32'd1);
        end
        if10.in_valid = 1'b0;
        chk("hold_valid",    32'(if10.out_valid), 32'd1);
        chk("hold_in_ready", 32'(if10.in_ready),  32'd0);
        chk("hold_acc",      32'(if10.out_acc),   32'd445);
        tick();
        chk("release_valid", 32'(if10.out_valid), 32'd0);
        chk("release_ready", 32'(if10.in_ready),  32'd1);

        // Backpressure: total held, second batch waits for the release
        if10.out_ready = 1'b0;
        for (int i = 0; i < 4; i++) begin
            if (i == 3) q10.push_back(445);
            feed10(batch[i]);
        end
        if10.in_valid = 1'b1;
        if10.in_sum   = 11'd1;
        for (int i = 0; i < 5; i++) begin
            chk("bp_valid",    32'(if10.out_valid), 32'd1);
            chk("bp_acc",      32'(if10.out_acc),   32'd445);
            chk("bp_in_ready", 32'(if10.in_ready),  32'd0);
            tick();
        end
        if10.out_ready = 1'b1;
        tick();
        for (int i = 0; i < 4; i++) begin
            if (i == 3) q10.push_back(4);
            feed10(1);
        end
        if10.in_valid = 1'b0;
        chk("bp2_acc", 32'(if10.out_acc), 32'd4);
        tick();

        // clear mid-batch drops the partial sum and the same-cycle sample
        feed10(5);
        feed10(7);
        clear10 = 1'b1;
        chk("clr_in_ready", 32'(if10.in_ready), 32'd1);
        feed10(9);
        clear10 = 1'b0;
        chk("clr_busy", 32'(busy10), 32'd0);
        for (int i = 1; i <= 4; i++) begin
            if (i == 4) q10.push_back(10);
            feed10(i);
        end
        if10.in_valid = 1'b0;
        tick();

        // clear during HOLD is ignored
        if10.out_ready = 1'b0;
        for (int i = 0; i < 4; i++) begin
            if (i == 3) q10.push_back(445);
            feed10(batch[i]);
        end
        if10.in_valid = 1'b0;
        clear10 = 1'b1;
        tick();
        clear10 = 1'b0;
        chk("clr_hold_valid", 32'(if10.out_valid), 32'd1);
        chk("clr_hold_acc",   32'(if10.out_acc),   32'd445);
        if10.out_ready = 1'b1;
        tick();

        // Reset while holding a total discards it
        if10.out_ready = 1'b0;
        for (int i = 0; i < 4; i++) feed10(batch[i]);
        if10.in_valid = 1'b0;
        chk("prerst_acc", 32'(if10.out_acc), 32'd445);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk("hrst_valid",    32'(if10.out_valid), 32'd0);
        chk("hrst_acc",      32'(if10.out_acc),   32'd0);
        chk("hrst_in_ready", 32'(if10.in_ready),  32'd1);
        if10.out_ready = 1'b1;
        for (int i = 1; i <= 4; i++) begin
            if (i == 4) q10.push_back(100);
            feed10(i * 10);
        end
        if10.in_valid = 1'b0;
        tick();

        // Maximum value, no wrap; idle sum changes are ignored
        if3.in_valid = 1'b0;
        if3.in_sum   = 4'd15;
        tick();
        chk("idle_busy", 32'(busy3), 32'd0);
        if3.in_valid = 1'b1;
        for (int i = 0; i < 4; i++) begin
            if (i == 3) q3.push_back(60);
            tick();
        end
        if3.in_valid = 1'b0;
        chk("max_acc", 32'(if3.out_acc), 32'd60);
        tick();

        // COUNT of one: each sample becomes a total, one-cycle in_ready gap
        if1.in_valid = 1'b1;
        if1.in_sum   = 4'd7;
        q1.push_back(7);
        tick();
        chk("c1_valid_a",    32'(if1.out_valid), 32'd1);
        chk("c1_in_ready_a", 32'(if1.in_ready),  32'd0);
        if1.in_sum = 4'd9;
        tick();
        chk("c1_gap_ready", 32'(if1.in_ready),  32'd1);
        chk("c1_gap_valid", 32'(if1.out_valid), 32'd0);
        q1.push_back(9);
        tick();
        if1.in_valid = 1'b0;
        chk("c1_valid_b", 32'(if1.out_valid), 32'd1);
        chk("c1_acc_b",   32'(if1.out_acc),   32'd9);
        tick();
        tick();

        // Every expected total must have appeared
        chk("sb10_drained", 32'(q10.size()), 32'd0);
        chk("sb3_drained",  32'(q3.size()),  32'd0);
        chk("sb1_drained",  32'(q1.size()),  32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
